// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide on unsigned magnitudes, sign fixed up in one extra cycle.
module mul_div_unit #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       MdCtrl,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_mul_op;
    logic               w_is_div_op;
    logic               w_is_signed;
    logic               w_div0;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_shift;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_is_mul_op = (MdCtrl == OP_MULT) || (MdCtrl == OP_MULTU);
    assign w_is_div_op = (MdCtrl == OP_DIV)  || (MdCtrl == OP_DIVU);
    assign w_is_signed = (MdCtrl == OP_MULT) || (MdCtrl == OP_DIV);
    assign w_div0      = w_is_div_op && (SrcB == '0);
    assign w_a_neg     = w_is_signed && SrcA[WIDTH-1];
    assign w_b_neg     = w_is_signed && SrcB[WIDTH-1];
    assign w_abs_a     = w_a_neg ? (~SrcA + 1'b1) : SrcA;
    assign w_abs_b     = w_b_neg ? (~SrcB + 1'b1) : SrcB;

    // Multiply: accumulator high half adds the multiplicand, then the whole pair shifts right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    // When the subtraction is taken the result is below the divisor, so WIDTH bits suffice.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_q_bit    = (w_shift >= {1'b0, r_opnd});
    assign w_diff     = w_shift[WIDTH-1:0] - r_opnd;
    assign w_rem_next = w_q_bit ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_step = {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};

    assign w_prod_fixed = r_neg_res ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_fix_hi = w_prod_fixed[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fixed[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_lo = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
            w_fix_hi = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (w_is_mul_op || w_is_div_op)) begin
                    w_state_next = w_div0 ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_count == LAST) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (MdCtrl == OP_MTHI) begin
                            r_hi <= SrcA;
                        end else if (MdCtrl == OP_MTLO) begin
                            r_lo <= SrcA;
                        end else if (w_div0) begin
                            r_hi <= SrcA;
                            r_lo <= DIV0_LO;
                        end else if (w_is_mul_op || w_is_div_op) begin
                            r_count   <= '0;
                            r_is_div  <= w_is_div_op;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            // Multiplicand / divisor stays put; the other operand rides in the low half.
                            r_opnd    <= w_is_div_op ? w_abs_b : w_abs_a;
                            r_acc     <= {{WIDTH{1'b0}}, (w_is_div_op ? w_abs_a : w_abs_b)};
                        end
                    end
                end
                S_CALC: begin
                    r_acc   <= r_is_div ? w_div_step : w_mul_step;
                    r_count <= r_count + 1'b1;
                end
                S_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized self-checking bench for mul_div_unit: a cycle-level behavioural model of
// HI/LO/busy/done is compared every cycle, plus literal checks of known results.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  MdCtrl = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    mul_div_unit #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst_n(rst_n), .SrcA(SrcA), .SrcB(SrcB), .MdCtrl(MdCtrl),
        .start(start), .busy(busy), .done(done), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'b0, a} * {32'b0, b};
            3'd3: begin
                sq = sa / sb;
                sr = sa % sb;
                r = {sr[31:0], sq[31:0]};
            end
            3'd4: r = {a % b, a / b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // m_rem counts edges left until the unit is idle again; result lands when one remains.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    int          m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi  <= '0;
            m_lo  <= '0;
            m_rem <= 0;
        end else if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            if (MdCtrl == 3'd5) begin
                m_hi <= SrcA;
            end else if (MdCtrl == 3'd6) begin
                m_lo <= SrcA;
            end else if ((MdCtrl == 3'd3 || MdCtrl == 3'd4) && SrcB == 32'd0) begin
                m_hi  <= SrcA;
                m_lo  <= 32'hFFFF_FFFF;
                m_rem <= 1;
            end else if (MdCtrl >= 3'd1 && MdCtrl <= 3'd4) begin
                m_pend <= ref_result(MdCtrl, SrcA, SrcB);
                m_rem  <= 34;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy", 64'(busy), 64'(m_rem != 0));
            check("cyc_done", 64'(done), 64'(m_rem == 1));
            check("cyc_hi", 64'(Hi), 64'(m_hi));
            check("cyc_lo", 64'(Lo), 64'(m_lo));
        end
    end

    // lat = edges after the start edge at which done is first seen (-1 if never).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output int lat);
        @(negedge clk);
        MdCtrl = op;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (done && lat < 0) lat = k;
            if (!busy) break;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                MdCtrl = 3'd4;
                SrcA = $urandom;
                SrcB = $urandom;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        if (busy) check("op_timeout", 64'(busy), 64'd0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, Hi, Lo, lat);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        armed = 1'b1;

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(Lo), 64'h0000_0001);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, lat);
        check("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(Lo), 64'hFFFF_FFEB);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, lat);
        check("div_lo", 64'(Lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(Hi), 64'hFFFF_FFFF);

        run_op(3'd4, 32'd100, 32'd0, 1'b0, lat);
        check("div0_lat", 64'(lat), 64'd0);
        check("div0_hi", 64'(Hi), 64'd100);
        check("div0_lo", 64'(Lo), 64'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        check("ovf_lo", 64'(Lo), 64'h8000_0000);
        check("ovf_hi", 64'(Hi), 64'd0);

        run_op(3'd1, 32'h0001_2345, 32'hFFFF_FF00, 1'b1, lat);
        check("noise_hi", 64'(Hi), 64'hFFFF_FFFF);
        check("noise_lo", 64'(Lo), 64'hFEDC_BB00);
        check("noise_lat", 64'(lat), 64'd33);

        run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0, lat);
        run_op(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, lat);
        check("mt_hi", 64'(Hi), 64'h1234_5678);
        check("mt_lo", 64'(Lo), 64'h9ABC_DEF0);
        check("mt_nodone", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

        run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, lat);
        check("nop_hi", 64'(Hi), 64'h1234_5678);
        check("nop_lo", 64'(Lo), 64'h9ABC_DEF0);

        // Abort a MULTU with reset while the iteration counter sits at 10.
        @(negedge clk);
        MdCtrl = 3'd2;
        SrcA = 32'd9;
        SrcB = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(Hi), 64'd0);
        check("abort_lo", 64'(Lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 64'({busy, done}), 64'd0);
        run_op(3'd2, 32'd5, 32'd6, 1'b0, lat);
        check("post_rst_lo", 64'(Lo), 64'd30);
        check("post_rst_hi", 64'(Hi), 64'd0);

        for (int n = 0; n < 150; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)), lat);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
